// File: rtl/corelet_out_stage.sv
// corelet_out_stage: collects MAC array south-edge outputs into per-column FIFOs.
// WS mode writes each column on its registered MAC valid; OS mode runs a
// skewed flush sequencer that writes `row` entries per column.
// Optional macro CORELET_OUT_RELU_EN: when defined, relu_en=1 clamps negative
// write data to zero; when undefined, relu_en is ignored.
module corelet_out_stage #(
  parameter int unsigned col     = 8,
  parameter int unsigned row     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 16,
  parameter int unsigned skew    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     os_or_ws,
  input  logic [col*psum_bw-1:0]   mac_out_s,
  input  logic [col-1:0]           mac_valid,
  input  logic                     flush_start,
  input  logic                     relu_en,
  input  logic                     rd,
  output logic [col*psum_bw-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned AW     = $clog2(depth);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned SPAN   = row + (col - 1) * skew;
  localparam int unsigned CW_RAW = $clog2(SPAN);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int unsigned LAST   = SPAN - 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [col*psum_bw-1:0] out_s_q;
  logic [col-1:0]         valid_q;
  logic [col-1:0]         wr;
  logic [col-1:0]         empty_v;
  logic [col-1:0]         full_v;
  logic [col-1:0]         drop_v;
  logic                   pop;

`ifndef CORELET_OUT_RELU_EN
  logic unused_relu;
  assign unused_relu = relu_en;
`endif

  // Capture stage: register MAC outputs and valids every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      out_s_q <= '0;
      valid_q <= '0;
    end else begin
      out_s_q <= mac_out_s;
      valid_q <= mac_valid;
    end
  end

  // Flush sequencer state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush sequencer next state: start on flush_start in OS, end after last skewed write
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (os_or_ws && flush_start) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        if (!os_or_ws || (cnt == CW'(LAST))) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-column write enables: registered valids in WS, skewed window in OS flush
  always_comb begin
    wr = '0;
    if (!os_or_ws) begin
      wr = valid_q;
    end else if (state == FLUSH) begin
      for (int unsigned c = 0; c < col; c++) begin
        wr[c] = (32'(cnt) >= c * skew) && (32'(cnt) < c * skew + row);
      end
    end
  end

  assign pop = rd && o_valid;

  for (genvar c = 0; c < int'(col); c++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [PW-1:0]      wp, rp;
    logic [psum_bw-1:0] din;
    logic               accept;

`ifdef CORELET_OUT_RELU_EN
    assign din = (relu_en && out_s_q[c*psum_bw + psum_bw - 1]) ? '0
                                                              : out_s_q[c*psum_bw +: psum_bw];
`else
    assign din = out_s_q[c*psum_bw +: psum_bw];
`endif

    assign empty_v[c] = (wp == rp);
    assign full_v[c]  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign accept     = wr[c] && (!full_v[c] || pop);
    assign drop_v[c]  = wr[c] && full_v[c] && !pop;

    // Column pointers: advance on accepted write and on global pop
    always_ff @(posedge clk) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (accept) wp <= wp + PW'(1);
        if (pop)    rp <= rp + PW'(1);
      end
    end

    // Column storage write
    always_ff @(posedge clk) begin
      if (!reset && accept) mem[wp[AW-1:0]] <= din;
    end

    assign out[c*psum_bw +: psum_bw] = mem[rp[AW-1:0]];
  end

  // Sticky overflow on any dropped write
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (|drop_v) overflow <= 1'b1;
  end

  assign o_valid = &(~empty_v);
  assign o_full  = |full_v;
  assign o_ready = !o_full;
  assign busy    = (state == FLUSH);

endmodule

// File: tb/tb_corelet_out_stage.sv
// Testbench for corelet_out_stage: directed stimulus, queue scoreboard and an
// independent negedge monitor that checks popped data and flag expectations.
module tb_corelet_out_stage;

  localparam int unsigned COL   = 8;
  localparam int unsigned ROW   = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SKEW  = 1;

  typedef logic [COL*PW-1:0] word_t;
  typedef struct {
    int         cyc;
    logic [4:0] flags;   // {o_valid, o_full, o_ready, busy, overflow}
  } fexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        os_or_ws = 1'b0;
  word_t       mac_out_s = '0;
  logic [COL-1:0] mac_valid = '0;
  logic        flush_start = 1'b0;
  logic        relu_en = 1'b0;
  logic        rd = 1'b0;
  word_t       out;
  logic        o_valid, o_full, o_ready, busy, overflow;

  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  logic        done = 1'b0;
  word_t       dq[$];
  fexp_t       fq[$];

  corelet_out_stage #(
    .col(COL), .row(ROW), .psum_bw(PW), .depth(DEPTH), .skew(SKEW)
  ) dut (
    .clk(clk), .reset(reset), .os_or_ws(os_or_ws), .mac_out_s(mac_out_s),
    .mac_valid(mac_valid), .flush_start(flush_start), .relu_en(relu_en), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic word_t word_of(input int base, input int stride);
    word_t w;
    for (int c = 0; c < int'(COL); c++) w[c*PW +: PW] = PW'(base + c * stride);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_flags(input logic v, input logic f, input logic b, input logic ov);
    fexp_t e;
    e.cyc   = cyc;
    e.flags = {v, f, !f, b, ov};
    fq.push_back(e);
  endtask

  task automatic ws_write(input word_t w, input logic [COL-1:0] m);
    mac_out_s = w;
    mac_valid = m;
    step();
    mac_valid = '0;
  endtask

  task automatic pop_n(input int n);
    rd = 1'b1;
    for (int i = 0; i < n; i++) step();
    rd = 1'b0;
  endtask

  // Full OS flush with busy/o_valid timing checks, then drain in write order
  task automatic run_flush();
    os_or_ws    = 1'b1;
    flush_start = 1'b1;
    mac_out_s   = word_of(0, 256);
    step();
    flush_start = 1'b0;
    expect_flags(1'b0, 1'b0, 1'b1, overflow);
    for (int j = 1; j <= 15; j++) begin
      mac_out_s = word_of(j, 256);
      step();
      expect_flags(j >= 8, 1'b0, j < 15, overflow);
    end
    for (int k = 0; k < int'(ROW); k++) dq.push_back(word_of(k, 257));
    pop_n(ROW);
    expect_flags(1'b0, 1'b0, 1'b0, overflow);
  endtask

  // Monitor: checks flag expectations and compares every popped head word
  always @(negedge clk) begin
    while (fq.size() > 0 && fq[0].cyc <= cyc) begin
      fexp_t e;
      logic [4:0] act;
      e   = fq.pop_front();
      act = {o_valid, o_full, o_ready, busy, overflow};
      n_run++;
      if (e.cyc != cyc || act !== e.flags) begin
        n_fail++;
        $display("FAIL flags cyc=%0d(exp cyc %0d) got {v,f,rdy,busy,ov}=%b want %b",
                 cyc, e.cyc, act, e.flags);
      end
    end
    if (rd && o_valid) begin
      n_run++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL pop cyc=%0d unexpected pop, got %h want none", cyc, out);
      end else begin
        word_t w;
        w = dq.pop_front();
        if (out !== w) begin
          n_fail++;
          $display("FAIL pop cyc=%0d got %h want %h", cyc, out, w);
        end
      end
    end
    if (done) begin
      n_run++;
      if (dq.size() != 0 || fq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover got dq=%0d fq=%0d want 0 0", dq.size(), fq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    word_t w;
    step();
    step();
    reset = 1'b0;
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // WS basic: column c = c+1, two-edge latency, single pop empties
    os_or_ws = 1'b0;
    ws_write(word_of(1, 1), 8'hFF);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_flags(1'b1, 1'b0, 1'b0, 1'b0);
    dq.push_back(word_of(1, 1));
    pop_n(1);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // rd with column 3 empty must not move any pointer
    ws_write(word_of(16'h100, 1), 8'hF7);
    step();
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);
    pop_n(1);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);
    ws_write(word_of(16'h200, 1), 8'h08);
    step();
    expect_flags(1'b1, 1'b0, 1'b0, 1'b0);
    w = word_of(16'h100, 1);
    w[3*PW +: PW] = 16'h0203;
    dq.push_back(w);
    pop_n(1);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // OS flush, skewed writes, busy window, ordered drain
    run_flush();

    // Overflow: depth+1 WS writes, last dropped; then pop+write on full
    os_or_ws  = 1'b0;
    mac_valid = 8'hFF;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      mac_out_s = word_of(16'h1000 + i, 1);
      step();
      expect_flags(i >= 1, i == int'(DEPTH), 1'b0, 1'b0);
    end
    mac_valid = '0;
    step();
    expect_flags(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) dq.push_back(word_of(16'h1000 + i, 1));
    ws_write(word_of(16'h1100, 1), 8'hFF);
    dq.push_back(word_of(16'h1100, 1));
    pop_n(1);
    expect_flags(1'b1, 1'b1, 1'b0, 1'b1);
    pop_n(DEPTH);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at cnt=5 mid-flush, then a clean full flush
    os_or_ws    = 1'b1;
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);
    run_flush();

    // ReLU on write path: negatives in even columns
    os_or_ws = 1'b0;
    relu_en  = 1'b1;
    for (int c = 0; c < int'(COL); c++) w[c*PW +: PW] = (c % 2 == 0) ? 16'hFFFD : 16'h0005;
    ws_write(w, 8'hFF);
    step();
    expect_flags(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CORELET_OUT_RELU_EN
    for (int c = 0; c < int'(COL); c += 2) w[c*PW +: PW] = 16'h0000;
`endif
    dq.push_back(w);
    pop_n(1);
    expect_flags(1'b0, 1'b0, 1'b0, 1'b0);
    relu_en = 1'b0;

    step();
    done = 1'b1;
    step();
    step();
  end

endmodule
